// File: rtl/latency_ctrl_pkg.sv
// Shared definitions for the latency_* delay-line blocks: FSM encoding and
// the width of delay-length fields.
package latency_ctrl_pkg;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // A delay of MAX_LEN must be representable, so one bit more than the address.
    function automatic int len_width(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

endpackage

// File: rtl/latency_ctrl_if.sv
// Sample stream and configuration port of the latency controller.
// Handshake: a request transfers on a rising edge where cfg_valid & cfg_ready;
// cfg_valid while cfg_ready=0 is ignored, so the requester holds it until taken.
interface latency_ctrl_if #(
    parameter int W  = 1,
    parameter int LW = 7
);
    logic          en;
    logic [W-1:0]  in;
    logic [LW-1:0] cfg_len;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_err;
    logic [LW-1:0] len;
    logic [W-1:0]  out;
    logic          out_valid;

    modport master (
        output en, in, cfg_len, cfg_valid,
        input  cfg_ready, cfg_err, len, out, out_valid
    );

    modport slave (
        input  en, in, cfg_len, cfg_valid,
        output cfg_ready, cfg_err, len, out, out_valid
    );
endinterface

// File: rtl/latency_ctrl_ram.sv
// Simple dual-port buffer: synchronous write, synchronous read, and a read of
// the address being written returns the old contents. No reset on purpose.
module latency_ctrl_ram #(
    parameter int W     = 1,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/latency_ctrl.sv
// Programmable delay line: circular buffer plus a PRIME/RUN sequencer that
// hides buffer contents until a full delay's worth of fresh samples is present.
module latency_ctrl
    import latency_ctrl_pkg::*;
#(
    parameter int W       = 1,
    parameter int MAX_LEN = 64,
    parameter int DEF_LEN = 8
) (
    input  logic   clk,
    input  logic   resetn,
    latency_ctrl_if.slave bus,
    output state_t dbg_state
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = len_width(MAX_LEN);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
    localparam logic [LW-1:0] DEF_L = LW'(DEF_LEN);

    state_t        state, state_nx;
    logic [LW-1:0] fill_cnt, fill_nx;
    logic [LW-1:0] len_q, len_nx;
    logic          err_q, err_nx;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  ram_q;
    logic [LW-1:0] len_req;
    logic          len_oor;

    always_comb begin
        len_req = bus.cfg_len;
        len_oor = 1'b0;
        if (bus.cfg_len == '0) begin
            len_req = LW'(1);
            len_oor = 1'b1;
        end else if (bus.cfg_len > MAX_L) begin
            len_req = MAX_L;
            len_oor = 1'b1;
        end
    end

    // Acceptance ignores en: reconfiguration must not wait for a stalled stream.
    always_comb begin
        state_nx = state;
        fill_nx  = fill_cnt;
        len_nx   = len_q;
        err_nx   = 1'b0;
        case (state)
            ST_PRIME: begin
                if (bus.en) begin
                    if (fill_cnt == len_q - LW'(1)) begin
                        state_nx = ST_RUN;
                        fill_nx  = '0;
                    end else begin
                        fill_nx = fill_cnt + LW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (bus.cfg_valid) begin
                    state_nx = ST_PRIME;
                    fill_nx  = '0;
                    len_nx   = len_req;
                    err_nx   = len_oor;
                end
            end
            default: state_nx = ST_PRIME;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_PRIME;
            fill_cnt <= '0;
            len_q    <= DEF_L;
            err_q    <= 1'b0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_nx;
            fill_cnt <= fill_nx;
            len_q    <= len_nx;
            err_q    <= err_nx;
            if (bus.en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    // len = MAX_LEN truncates to 0, so read and write share an address.
    assign rd_addr = wr_ptr - len_q[AW-1:0];

    latency_ctrl_ram #(
        .W     (W),
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (bus.en),
        .waddr (wr_ptr),
        .wdata (bus.in),
        .re    (bus.en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    assign bus.cfg_ready = (state == ST_RUN);
    assign bus.out_valid = (state == ST_RUN);
    assign bus.out       = (state == ST_RUN) ? ram_q : '0;
    assign bus.len       = len_q;
    assign bus.cfg_err   = err_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_latency_ctrl.sv
// Bench for latency_ctrl: behavioural model (sample history + enabled-edge
// count since last restart) checked every cycle, plus directed literal checks.
module tb_latency_ctrl;
  import latency_ctrl_pkg::*;

  localparam int W       = 8;
  localparam int MAX_LEN = 64;
  localparam int DEF_LEN = 8;
  localparam int LW      = 7;

  logic   clk = 1'b0;
  logic   resetn = 1'b0;
  state_t dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Model: every sample taken on an enabled edge since reset, the delay in
  // force, and the number of enabled edges since the last (re)start.
  logic [W-1:0] exp_q[$];
  int           m_len = DEF_LEN;
  int           since = 0;
  logic         m_err = 1'b0;

  logic [W-1:0] cnt = 8'h10;

  latency_ctrl_if #(.W(W), .LW(LW)) bus ();

  latency_ctrl #(
    .W       (W),
    .MAX_LEN (MAX_LEN),
    .DEF_LEN (DEF_LEN)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model, advanced on each rising edge
  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        exp_q.delete();
        m_len = DEF_LEN;
        since = 0;
        m_err = 1'b0;
      end else begin
        bit acc;
        acc = (since >= m_len) && bus.cfg_valid;
        m_err = 1'b0;
        if (acc) begin
          m_err = (bus.cfg_len == 0) || (int'(bus.cfg_len) > MAX_LEN);
          if (bus.cfg_len == 0) m_len = 1;
          else if (int'(bus.cfg_len) > MAX_LEN) m_len = MAX_LEN;
          else m_len = int'(bus.cfg_len);
          since = 0;
        end
        if (bus.en) begin
          exp_q.push_back(bus.in);
          if (!acc) since++;
        end
      end
    end
  end

  // scoreboard compare, on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit v;
        int idx;
        v = (since >= m_len);
        chk("out_valid", 32'(bus.out_valid), 32'(v));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(v));
        chk("state_run", 32'(dbg_state == ST_RUN), 32'(v));
        chk("len", 32'(bus.len), 32'(m_len));
        chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
        idx = exp_q.size() - m_len - 1;
        if (!v) chk("out_idle", 32'(bus.out), 32'h0);
        else if (idx >= 0) chk("out_data", 32'(bus.out), 32'(exp_q[idx]));
      end
    end
  end

  // driver tasks
  task automatic step(input logic e, input logic [W-1:0] d);
    bus.en = e;
    bus.in = d;
    @(negedge clk);
  endtask

  task automatic cfg_req(input logic [LW-1:0] l, output int steps, output logic [W-1:0] acc_in);
    logic rdy;
    steps = 0;
    acc_in = '0;
    rdy = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_len = l;
    while (!rdy && steps < 200) begin
      rdy = bus.cfg_ready;
      acc_in = cnt;
      step(1'b1, cnt);
      cnt++;
      steps++;
    end
    bus.cfg_valid = 1'b0;
    chk("cfg_accept", 32'(rdy), 32'h1);
  endtask

  task automatic reset_pulse(input string tag);
    #2 resetn = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, "_rst_ready"}, 32'(bus.cfg_ready), 32'h0);
    chk({tag, "_rst_out"}, 32'(bus.out), 32'h0);
    chk({tag, "_rst_len"}, 32'(bus.len), 32'(DEF_LEN));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, cnt);
      cnt++;
      if (i == 7) chk({tag, "_reprime_7"}, 32'(bus.out_valid), 32'h0);
      if (i == 8) chk({tag, "_reprime_8"}, 32'(bus.out_valid), 32'h1);
    end
  endtask

  // stimulus
  initial begin
    int st;
    logic [W-1:0] ai;
    bus.en = 1'b0;
    bus.in = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_len = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_len", 32'(bus.len), 32'(DEF_LEN));
    chk("reset_out", 32'(bus.out), 32'h0);
    resetn = 1'b1;

    // default delay primes in 8 edges, then out = in delayed by 8
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, cnt);
      cnt++;
      if (i == 7) chk("t1_valid_7", 32'(bus.out_valid), 32'h0);
      if (i == 8) chk("t1_valid_8", 32'(bus.out_valid), 32'h1);
      if (i == 8) chk("t1_ready_8", 32'(bus.cfg_ready), 32'h1);
      if (i == 9) chk("t1_out_9", 32'(bus.out), 32'h10);
      if (i == 12) chk("t1_out_12", 32'(bus.out), 32'h13);
    end

    // in-range reconfiguration to 3
    cfg_req(7'd3, st, ai);
    chk("t2_steps", 32'(st), 32'h1);
    chk("t2_len", 32'(bus.len), 32'h3);
    chk("t2_err", 32'(bus.cfg_err), 32'h0);
    chk("t2_valid_0", 32'(bus.out_valid), 32'h0);
    step(1'b1, cnt); cnt++;
    step(1'b1, cnt); cnt++;
    chk("t2_valid_2", 32'(bus.out_valid), 32'h0);
    step(1'b1, cnt); cnt++;
    chk("t2_valid_3", 32'(bus.out_valid), 32'h1);
    chk("t2_out_3", 32'(bus.out), 32'(ai));

    // clamping: 0 -> 1, 100 -> 64
    cfg_req(7'd0, st, ai);
    chk("t3_err_lo", 32'(bus.cfg_err), 32'h1);
    chk("t3_len_lo", 32'(bus.len), 32'h1);
    step(1'b1, cnt); cnt++;
    chk("t3_err_lo_end", 32'(bus.cfg_err), 32'h0);
    chk("t3_valid_1", 32'(bus.out_valid), 32'h1);
    chk("t3_out_1", 32'(bus.out), 32'(ai));
    repeat (5) begin step(1'b1, cnt); cnt++; end
    cfg_req(7'd100, st, ai);
    chk("t3_err_hi", 32'(bus.cfg_err), 32'h1);
    chk("t3_len_hi", 32'(bus.len), 32'd64);
    step(1'b1, cnt); cnt++;
    chk("t3_err_hi_end", 32'(bus.cfg_err), 32'h0);

    // request held through a 64-cycle prime is taken exactly when RUN begins
    cfg_req(7'd5, st, ai);
    chk("t5_wait", 32'(st), 32'd64);
    chk("t5_len", 32'(bus.len), 32'd5);
    chk("t5_err", 32'(bus.cfg_err), 32'h0);

    // full-length delay with en toggling randomly, pointer wraps many times
    cfg_req(7'd64, st, ai);
    repeat (400) step(1'($urandom_range(0, 1)), W'($urandom));

    // random reconfiguration traffic, including out-of-range lengths
    repeat (400) begin
      bus.cfg_valid = ($urandom_range(0, 9) == 0);
      bus.cfg_len = LW'($urandom_range(0, 127));
      step(1'($urandom_range(0, 1)), W'($urandom));
    end
    bus.cfg_valid = 1'b0;

    // asynchronous reset mid-RUN and mid-PRIME
    cfg_req(7'd4, st, ai);
    repeat (6) begin step(1'b1, cnt); cnt++; end
    chk("t6_run_before", 32'(bus.out_valid), 32'h1);
    reset_pulse("t6_run");
    cfg_req(7'd30, st, ai);
    repeat (5) begin step(1'b1, cnt); cnt++; end
    reset_pulse("t6_prime");

    repeat (3) begin step(1'b1, cnt); cnt++; end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
